vga_frame_reader: RTL and testbench

//  Read side of the 320x240 RGB444 camera frame buffer. Generates 640x480@60 VGA timing,

---
 rtl/vga_frame_reader.sv | 148 ++++++++++++++
 tb/tb_vga_frame_reader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: 640x480@60 VGA timing with 2x upscaled reads from a 320x240 RGB444 frame buffer.
// Build option VGA_READER_GRAY_EN: the output stage drives 4-bit luma on all three channels.
module vga_frame_reader #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int FB_W     = 320,
   parameter int RD_LAT   = 1
) (
   input  logic        pclk,
   input  logic        reset,
   output logic        oe,
   output logic [16:0] rAddr,
   input  logic [11:0] rData,
   output logic        h_sync,
   output logic        v_sync,
   output logic        de,
   output logic [9:0]  x_pixel,
   output logic [9:0]  y_pixel,
   output logic [3:0]  red,
   output logic [3:0]  green,
   output logic [3:0]  blue,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0]  H_VIS  = 10'(H_ACTIVE);
   localparam logic [9:0]  V_VIS  = 10'(V_ACTIVE);
   localparam logic [9:0]  HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]  HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [16:0] FB_W17 = 17'(FB_W);

   typedef struct packed {
      logic       de;
      logic       hs;
      logic       vs;
      logic       fs;
      logic [9:0] x;
      logic [9:0] y;
   } ctl_t;

   localparam ctl_t CTL_IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, x: 10'd0, y: 10'd0};

   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic       active0;
   ctl_t       ctl0;
   ctl_t       ctl_out;
   ctl_t       ctl_pipe [RD_LAT+1];
   logic [3:0] pix_r;
   logic [3:0] pix_g;
   logic [3:0] pix_b;

   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
         h_cnt <= h_cnt + 10'd1;
      end
   end

   always_comb begin
      active0 = (h_cnt < H_VIS) && (v_cnt < V_VIS);
      ctl0    = CTL_IDLE;
      ctl0.de = active0;
      ctl0.hs = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
      ctl0.vs = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
      ctl0.fs = (h_cnt == '0) && (v_cnt == '0);
      ctl0.x  = h_cnt;
      ctl0.y  = v_cnt;
   end

   // Control is delayed 1+RD_LAT stages so it meets the read data at the output register.
   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         oe    <= 1'b0;
         rAddr <= '0;
         for (int i = 0; i <= RD_LAT; i++) ctl_pipe[i] <= CTL_IDLE;
      end else begin
         oe <= active0;
         if (active0) rAddr <= 17'(v_cnt[9:1]) * FB_W17 + 17'(h_cnt[9:1]);
         ctl_pipe[0] <= ctl0;
         for (int i = 1; i <= RD_LAT; i++) ctl_pipe[i] <= ctl_pipe[i-1];
      end
   end

   assign ctl_out = ctl_pipe[RD_LAT];

`ifdef VGA_READER_GRAY_EN
   logic [6:0] luma_sum;
   always_comb begin
      luma_sum = {2'b00, rData[11:8], 1'b0} + (7'(rData[7:4]) * 7'd5) + {3'b000, rData[3:0]};
      pix_r    = 4'(luma_sum >> 3);
      pix_g    = pix_r;
      pix_b    = pix_r;
   end
`else
   assign pix_r = rData[11:8];
   assign pix_g = rData[7:4];
   assign pix_b = rData[3:0];
`endif

   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         de          <= 1'b0;
         h_sync      <= 1'b1;
         v_sync      <= 1'b1;
         frame_start <= 1'b0;
         x_pixel     <= '0;
         y_pixel     <= '0;
         red         <= '0;
         green       <= '0;
         blue        <= '0;
      end else begin
         de          <= ctl_out.de;
         h_sync      <= ctl_out.hs;
         v_sync      <= ctl_out.vs;
         frame_start <= ctl_out.fs;
         if (ctl_out.de) begin
            x_pixel <= ctl_out.x;
            y_pixel <= ctl_out.y;
            red     <= pix_r;
            green   <= pix_g;
            blue    <= pix_b;
         end else begin
            red     <= '0;
            green   <= '0;
            blue    <= '0;
         end
      end
   end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader: full-width lines, frame shortened to 22 lines (16 visible).
// Honours VGA_READER_GRAY_EN for the expected pixel colours.
module tb_vga_frame_reader;

   localparam int H_T   = 800;
   localparam int V_A   = 16;
   localparam int V_T   = 22;
   localparam int FRAME = H_T * V_T;

`ifdef VGA_READER_GRAY_EN
   localparam logic [11:0] EXP_123 = 12'h111;
   localparam logic [11:0] EXP_A5C = 12'h777;
   localparam logic [11:0] EXP_F82 = 12'h999;
   localparam logic [11:0] EXP_FFF = 12'hFFF;
`else
   localparam logic [11:0] EXP_123 = 12'h123;
   localparam logic [11:0] EXP_A5C = 12'hA5C;
   localparam logic [11:0] EXP_F82 = 12'hF82;
   localparam logic [11:0] EXP_FFF = 12'hFFF;
`endif

   logic        pclk;
   logic        reset;
   logic        oe;
   logic [16:0] rAddr;
   logic [11:0] rData;
   logic        h_sync, v_sync, de, frame_start;
   logic [9:0]  x_pixel, y_pixel;
   logic [3:0]  red, green, blue;

   int checks = 0;
   int failures = 0;
   int k = 0;
   int err_s1 = 0, err_out = 0;
   int de_cnt = 0, hs_lo = 0, vs_lo = 0;
   int fs_cnt = 0, fs_k1 = 0, fs_k2 = 0;
   logic [16:0] m_addr = '0;
   logic [9:0]  m_x = '0, m_y = '0;

   vga_frame_reader #(.V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut (
      .pclk(pclk), .reset(reset), .oe(oe), .rAddr(rAddr), .rData(rData),
      .h_sync(h_sync), .v_sync(v_sync), .de(de), .x_pixel(x_pixel), .y_pixel(y_pixel),
      .red(red), .green(green), .blue(blue), .frame_start(frame_start)
   );

   initial pclk = 1'b0;
   always #20 pclk = ~pclk;

   function automatic logic [11:0] fb_word(input logic [16:0] a);
      if (a == 17'd645) return 12'hA5C;
      if (a == 17'd646) return 12'hF82;
      if (a == 17'd647) return 12'hFFF;
      return a[11:0] ^ 12'h123;
   endfunction

   function automatic logic [11:0] exp_col(input logic [11:0] d);
`ifdef VGA_READER_GRAY_EN
      int y;
      y = (2 * d[11:8] + 5 * d[7:4] + d[3:0]) >> 3;
      return {4'(y), 4'(y), 4'(y)};
`else
      return d;
`endif
   endfunction

   // Frame buffer with one cycle of read latency; unread cycles return garbage.
   always @(posedge pclk) rData <= oe ? fb_word(rAddr) : 12'hFFF;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_cycle();
      int p, h, v;
      logic e_oe, e_de, e_hs, e_vs, e_fs;
      logic [11:0] e_rgb;
      p = k - 1; h = p % H_T; v = (p / H_T) % V_T;
      e_oe = (h < 640) && (v < V_A);
      if (e_oe) m_addr = 17'((v / 2) * 320 + h / 2);
      if (oe !== e_oe || rAddr !== m_addr) err_s1++;
      e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_rgb = '0;
      if (k >= 3) begin
         p = k - 3; h = p % H_T; v = (p / H_T) % V_T;
         e_de = (h < 640) && (v < V_A);
         e_hs = !(h >= 656 && h < 752);
         e_vs = !(v >= V_A + 2 && v < V_A + 4);
         e_fs = (h == 0) && (v == 0);
         if (e_de) begin
            m_x = 10'(h);
            m_y = 10'(v);
            e_rgb = exp_col(fb_word(17'((v / 2) * 320 + h / 2)));
         end
      end
      if (de !== e_de || h_sync !== e_hs || v_sync !== e_vs || frame_start !== e_fs ||
          x_pixel !== m_x || y_pixel !== m_y || {red, green, blue} !== e_rgb) err_out++;
      if (k >= 3 && k <= FRAME + 2) begin
         if (de === 1'b1) de_cnt++;
         if (h_sync === 1'b0) hs_lo++;
         if (v_sync === 1'b0) vs_lo++;
      end
      if (frame_start === 1'b1) begin
         fs_cnt++;
         if (fs_cnt == 1) fs_k1 = k;
         if (fs_cnt == 2) fs_k2 = k;
      end
   endtask

   task automatic goto(input int kt);
      while (k < kt) begin
         @(negedge pclk);
         k++;
         check_cycle();
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_oe"}, oe, 1'b0);
      check({tag, "_raddr"}, rAddr, 17'd0);
      check({tag, "_sync"}, {h_sync, v_sync}, 2'b11);
      check({tag, "_de_fs"}, {de, frame_start}, 2'b00);
      check({tag, "_xy"}, {x_pixel, y_pixel}, 20'd0);
      check({tag, "_rgb"}, {red, green, blue}, 12'h000);
   endtask

   initial begin
      reset = 1'b0;
      repeat (3) @(negedge pclk);
      check_reset_outputs("por");
      reset = 1'b1;
      k = 0;

      goto(1);
      check("k1_oe", oe, 1'b1);
      check("k1_raddr", rAddr, 17'd0);
      check("k1_de", de, 1'b0);
      goto(2);
      check("k2_fs", frame_start, 1'b0);
      goto(3);
      check("k3_de_fs", {de, frame_start}, 2'b11);
      check("k3_xy", {x_pixel, y_pixel}, 20'd0);
      check("k3_rgb", {red, green, blue}, EXP_123);
      goto(4);
      check("k4_fs", frame_start, 1'b0);
      check("k4_raddr", rAddr, 17'd1);

      goto(640);  check("line0_last_addr", {oe, rAddr}, {1'b1, 17'd319});
      goto(641);  check("line0_blank_oe", {oe, rAddr}, {1'b0, 17'd319});
      goto(801);  check("line1_first", {oe, rAddr}, {1'b1, 17'd0});
      goto(1601); check("line2_first", rAddr, 17'd320);
      goto(1603); check("line2_third", rAddr, 17'd321);

      goto(658);  // already passed; no-op
      goto(1600 + 658); check("hs_before", h_sync, 1'b1);
      goto(1600 + 659); check("hs_first_low", h_sync, 1'b0);
      goto(1600 + 754); check("hs_last_low", h_sync, 1'b0);
      goto(1600 + 755); check("hs_after", h_sync, 1'b1);

      goto(3213);
      check("px10_4_rgb", {red, green, blue}, EXP_A5C);
      check("px10_4_xy", {x_pixel, y_pixel}, {10'd10, 10'd4});
      goto(3215); check("px12_4_rgb", {red, green, blue}, EXP_F82);
      goto(3217); check("px14_4_rgb", {red, green, blue}, EXP_FFF);
      goto(3903);
      check("blank_rgb", {de, red, green, blue}, 13'h0000);
      check("blank_xy_hold", {x_pixel, y_pixel}, {10'd639, 10'd4});

      goto(12640); check("last_line_addr", rAddr, 17'd2559);
      goto(12641); check("last_line_blank", {oe, rAddr}, {1'b0, 17'd2559});
      goto(14402); check("vs_before", v_sync, 1'b1);
      goto(14403); check("vs_first_low", v_sync, 1'b0);
      goto(16002); check("vs_last_low", v_sync, 1'b0);
      goto(16003); check("vs_after", v_sync, 1'b1);

      goto(FRAME + 3);
      check("frame2_fs", {frame_start, de}, 2'b11);
      check("fs_count", fs_cnt, 2);
      check("fs_period", fs_k2 - fs_k1, FRAME);
      check("de_cycles", de_cnt, 16 * 640);
      check("hs_low_cycles", hs_lo, V_T * 96);
      check("vs_low_cycles", vs_lo, 2 * H_T);

      goto(FRAME + 10 * H_T + 300);
      check("pre_reset_de", de, 1'b1);
      reset = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      repeat (5) @(negedge pclk);
      check_reset_outputs("mid_rst_hold");
      reset = 1'b1;
      k = 0; m_addr = '0; m_x = '0; m_y = '0;
      goto(1);
      check("rst_k1", {oe, rAddr}, {1'b1, 17'd0});
      goto(2);
      check("rst_k2_fs", frame_start, 1'b0);
      goto(3);
      check("rst_k3_fs", {frame_start, de}, 2'b11);
      check("rst_k3_rgb", {red, green, blue}, EXP_123);
      goto(900);

      check("stage1_model_errors", err_s1, 0);
      check("output_model_errors", err_out, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
